// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle done pulse, one-shot or auto-reload operation.
// Optional macro COUNTDOWN_TIMER_DONE_CNT_EN adds a saturating done_cnt output.
module countdown_timer #(
   parameter int unsigned NUM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                clear,
   input  logic                load,
   input  logic [NUM_BITS-1:0] load_val,
   input  logic                reload,
   output logic [NUM_BITS-1:0] count,
   output logic                at_zero,
   output logic                done,
   output logic                busy,
   output logic                expired
`ifdef COUNTDOWN_TIMER_DONE_CNT_EN
   ,
   output logic [NUM_BITS-1:0] done_cnt
`endif
);

   localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   state_t              state;
   logic [NUM_BITS-1:0] reload_reg;
   logic                terminal;

   assign at_zero  = (count == '0);
   // Terminal edge: enabled decrement from 1 while running, with no clear/load override.
   assign terminal = !clear && !load && (state == ST_RUN) && enable && (count == ONE);

   // State, count and registered status outputs; clear > load > decrement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         count      <= '0;
         reload_reg <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
         expired    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            state   <= ST_IDLE;
            count   <= '0;
            busy    <= 1'b0;
            expired <= 1'b0;
         end else if (load) begin
            reload_reg <= load_val;
            count      <= load_val;
            expired    <= 1'b0;
            if (load_val != '0) begin
               state <= ST_RUN;
               busy  <= 1'b1;
            end else begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         end else begin
            case (state)
               ST_RUN: begin
                  if (terminal) begin
                     done <= 1'b1;
                     if (reload) begin
                        count <= reload_reg;
                     end else begin
                        count   <= '0;
                        state   <= ST_EXPIRED;
                        busy    <= 1'b0;
                        expired <= 1'b1;
                     end
                  end else if (enable && (count != '0)) begin
                     count <= count - ONE;
                  end
               end
               ST_EXPIRED: begin
                  count <= '0;
               end
               default: begin
               end
            endcase
         end
      end
   end

`ifdef COUNTDOWN_TIMER_DONE_CNT_EN
   // Saturating tally of done pulses; load leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_cnt <= '0;
      end else if (clear) begin
         done_cnt <= '0;
      end else if (terminal && (done_cnt != '1)) begin
         done_cnt <= done_cnt + ONE;
      end
   end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; done_cnt checks follow
// COUNTDOWN_TIMER_DONE_CNT_EN.
module tb_countdown_timer;

   localparam int unsigned NB = 8;

   logic          clk;
   logic          rst;
   logic          enable;
   logic          clear;
   logic          load;
   logic [NB-1:0] load_val;
   logic          reload;
   logic [NB-1:0] count;
   logic          at_zero;
   logic          done;
   logic          busy;
   logic          expired;
`ifdef COUNTDOWN_TIMER_DONE_CNT_EN
   logic [NB-1:0] done_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int exp_cnt;
   int done_seen;

   countdown_timer #(.NUM_BITS(NB)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .reload   (reload),
      .count    (count),
      .at_zero  (at_zero),
      .done     (done),
      .busy     (busy),
      .expired  (expired)
`ifdef COUNTDOWN_TIMER_DONE_CNT_EN
      ,
      .done_cnt (done_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with active-looking inputs
      rst = 1'b1; enable = 1'b1; clear = 1'b0; load = 1'b1; load_val = 8'd5; reload = 1'b0;
      #1;
      check("rst_count_async", 32'(count), 32'd0);
      step();
      step();
      check("rst_count", 32'(count), 32'd0);
      check("rst_at_zero", 32'(at_zero), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_expired", 32'(expired), 32'd0);
`ifdef COUNTDOWN_TIMER_DONE_CNT_EN
      check("rst_done_cnt", 32'(done_cnt), 32'd0);
`endif
      load = 1'b0;
      #2;
      rst = 1'b0;
      step();
      step();
      check("post_rst_count", 32'(count), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      // One-shot from 5
      load = 1'b1; load_val = 8'd5; reload = 1'b0; enable = 1'b1;
      step();
      load = 1'b0;
      check("os_load_count", 32'(count), 32'd5);
      check("os_load_busy", 32'(busy), 32'd1);
      check("os_load_done", 32'(done), 32'd0);
      for (int i = 4; i >= 1; i--) begin
         step();
         check("os_count", 32'(count), 32'(i));
         check("os_done_low", 32'(done), 32'd0);
      end
      step();
      check("os_final_count", 32'(count), 32'd0);
      check("os_final_done", 32'(done), 32'd1);
      check("os_expired", 32'(expired), 32'd1);
      check("os_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         check("os_hold_count", 32'(count), 32'd0);
         check("os_hold_done", 32'(done), 32'd0);
      end
      check("os_hold_expired", 32'(expired), 32'd1);

      // Auto-reload with period 3
      load = 1'b1; load_val = 8'd3; reload = 1'b1; enable = 1'b1;
      step();
      load = 1'b0;
      check("ar_load_count", 32'(count), 32'd3);
      check("ar_load_expired", 32'(expired), 32'd0);
      for (int p = 0; p < 4; p++) begin
         step();
         check("ar_count2", 32'(count), 32'd2);
         check("ar_done2", 32'(done), 32'd0);
         step();
         check("ar_count1", 32'(count), 32'd1);
         check("ar_done1", 32'(done), 32'd0);
         step();
         check("ar_count3", 32'(count), 32'd3);
         check("ar_done3", 32'(done), 32'd1);
         check("ar_busy", 32'(busy), 32'd1);
         check("ar_expired", 32'(expired), 32'd0);
      end

      // Enable gating: alternate enable each cycle
      load = 1'b1; load_val = 8'd10; reload = 1'b0; enable = 1'b0;
      step();
      load = 1'b0;
      check("eg_load_count", 32'(count), 32'd10);
      exp_cnt   = 10;
      done_seen = 0;
      for (int k = 0; k < 20; k++) begin
         enable = (k % 2 == 0);
         step();
         if (enable && exp_cnt > 0) exp_cnt--;
         if (done) done_seen++;
         check("eg_count", 32'(count), 32'(exp_cnt));
      end
      check("eg_final_zero", 32'(count), 32'd0);
      check("eg_done_total", 32'(done_seen), 32'd1);
      check("eg_expired", 32'(expired), 32'd1);

      // Priority: clear beats load, load beats decrement
      load = 1'b1; load_val = 8'd10; enable = 1'b1;
      step();
      load = 1'b0;
      step();
      step();
      step();
      check("pr_count7", 32'(count), 32'd7);
      clear = 1'b1; load = 1'b1; load_val = 8'd20;
      step();
      clear = 1'b0;
      check("pr_clear_count", 32'(count), 32'd0);
      check("pr_clear_busy", 32'(busy), 32'd0);
      check("pr_clear_expired", 32'(expired), 32'd0);
      check("pr_clear_done", 32'(done), 32'd0);
      step();
      check("pr_load_count", 32'(count), 32'd20);
      check("pr_load_busy", 32'(busy), 32'd1);
      load_val = 8'd0;
      step();
      load = 1'b0;
      check("pr_load0_count", 32'(count), 32'd0);
      check("pr_load0_busy", 32'(busy), 32'd0);
      check("pr_load0_done", 32'(done), 32'd0);
      check("pr_load0_at_zero", 32'(at_zero), 32'd1);
      step();
      check("pr_idle_hold", 32'(count), 32'd0);

      // Async reset mid-run
      load = 1'b1; load_val = 8'd6; enable = 1'b1;
      step();
      load = 1'b0;
      step();
      step();
      check("ar_mid_count4", 32'(count), 32'd4);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", 32'(count), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_at_zero", 32'(at_zero), 32'd1);
      #1;
      rst = 1'b0;
      step();
      check("arst_idle_count", 32'(count), 32'd0);

`ifdef COUNTDOWN_TIMER_DONE_CNT_EN
      check("dc_after_rst", 32'(done_cnt), 32'd0);
      for (int n = 0; n < 3; n++) begin
         load = 1'b1; load_val = 8'd2; reload = 1'b0; enable = 1'b1;
         step();
         load = 1'b0;
         step();
         step();
         check("dc_expiry_done", 32'(done), 32'd1);
      end
      check("dc_three", 32'(done_cnt), 32'd3);
      load = 1'b1; load_val = 8'd4;
      step();
      load = 1'b0;
      check("dc_load_keeps", 32'(done_cnt), 32'd3);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("dc_clear", 32'(done_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable, programmable down-counter: the count-down counterpart of the team's up-counter block.
- Counts from a loaded value to zero and flags expiry with a one-cycle done pulse.
- Optionally auto-reloads so it acts as a periodic tick generator for timeouts, baud/strobe generation and watchdogs.
- Sits alongside the up-counter in the counter library and shares its enable/clear semantics.

Parameters:
- NUM_BITS, 8, width of count, load value and stored reload value.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  decrement permission while running.
- clear  input  1  synchronous clear, highest synchronous priority.
- load  input  1  synchronous load strobe.
- load_val  input  NUM_BITS  start value; also captured as the reload value.
- reload  input  1  auto-reload at terminal count (1) vs one-shot (0).
- count  output  NUM_BITS  current count value.
- at_zero  output  1  combinational, high when count == 0.
- done  output  1  registered one-cycle pulse at terminal count.
- busy  output  1  high in state RUN.
- expired  output  1  high in state EXPIRED (sticky).

Behaviour:
- States: IDLE, RUN, EXPIRED.
- Reset (async, immediate, no clock edge needed): count=0, reload register=0, state=IDLE, done=0, busy=0, expired=0, at_zero=1.
- Synchronous priority, highest first: clear > load > decrement.
- clear: count<=0, state<=IDLE, done<=0. Reload register is retained. Applies in every state.
- load (no clear):
  - reload_reg<=load_val and count<=load_val.
  - If load_val != 0: state<=RUN. If load_val == 0: state<=IDLE.
  - No done pulse in either case.
  - Load overrides a decrement in the same cycle.
- RUN, enable=0: count holds.
- RUN, enable=1, count > 1: count<=count-1.
- RUN, enable=1, count == 1 (terminal):
  - done<=1 for exactly one cycle.
  - reload=1: count<=reload_reg, stay in RUN; the period is exactly reload_reg enabled cycles.
  - reload=0: count<=0, state<=EXPIRED.
  - reload is sampled only at the terminal edge.
- EXPIRED: count holds 0, no further done pulses, enable ignored. Exits only via load or clear.
- IDLE: count holds, enable ignored.
- done is low in every cycle other than the cycle following a terminal edge.
- Arithmetic:
  - Plain NUM_BITS-wide unsigned decrement.
  - The counter never underflows: 0 is never decremented.
  - Maximum load value is 2^NUM_BITS-1.
- Load during RUN restarts the count cleanly from load_val; the old count is discarded.

Optional Feature:
- Macro: COUNTDOWN_TIMER_DONE_CNT_EN.
- Defined:
  - Adds output done_cnt (NUM_BITS wide).
  - Increments on every done pulse and saturates at 2^NUM_BITS-1 (no wrap).
  - Cleared to 0 by rst or clear; unaffected by load.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset:
   - Stimulus: rst=1 with enable=1, load=1, load_val=5.
   - Response: count=0, at_zero=1, busy=0, done=0, expired=0.
   - After release with load=0: count stays 0 and state stays IDLE.
2. One-shot:
   - Stimulus: load 5, reload=0, enable=1.
   - Response: count 5,4,3,2,1,0 on successive cycles; done high only in the cycle count=0.
   - Then expired=1, busy=0, and count holds 0 for 10 more cycles with no done.
3. Auto-reload:
   - Stimulus: load 3, reload=1, enable=1.
   - Response: count 3,2,1,3,2,1,... with done high each time count returns to 3, i.e. every 3 cycles for 4 periods.
   - busy stays 1 and expired stays 0.
4. Enable gating:
   - Stimulus: load 10, reload=0, enable alternating 1/0 each cycle.
   - Response: count decrements only after enabled edges and reaches 0 after 20 cycles; exactly one done.
5. Priority:
   - In RUN at count=7, assert clear and load (load_val=20) together: count=0, IDLE.
   - Then load 20 with enable=1: count=20 on the next cycle, not 19.
   - Then load 0: IDLE, no done.
6. Async reset mid-run:
   - Stimulus: at count=4 with enable=1, raise rst between clock edges.
   - Response: count=0, busy=0, done=0 immediately, without waiting for a clock edge.
   - With COUNTDOWN_TIMER_DONE_CNT_EN: done_cnt=0 after reset; after 3 one-shot expiries, done_cnt=3.
